// File: rtl/id_defs_pkg.sv
// Shared decode definitions for the ID stage: opcodes, MEM-slot codes,
// slot field positions, FSM encodings and small helpers.
package id_defs;

  localparam int NREGS = 8;
  localparam int RW    = 3;
  localparam int IMMW  = 3;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_BRN  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;

  // Opcode field values carried by the MEM slot
  localparam logic [3:0] MOP_LOAD  = 4'd1;
  localparam logic [3:0] MOP_STORE = 4'd2;

  // Encoded MEM op driven into ID/EX
  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  function automatic logic [31:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(32-IMMW){imm[IMMW-1]}}, imm};
  endfunction

  // r0 is hardwired to zero regardless of what the register file returns
  function automatic logic [31:0] reg_val(input logic [RW-1:0] addr, input logic [31:0] data);
    return (addr == '0) ? 32'd0 : data;
  endfunction

endpackage

// File: rtl/id_stage_slot_decode.sv
// Decodes one 16-bit issue slot into fields and register-usage flags.
// IS_MEM selects the MEM-slot opcode map instead of the ALU map.
module id_slot_decode
  import id_defs::*;
#(
  parameter bit IS_MEM = 1'b0
) (
  input  logic [15:0]   instr,
  output logic [3:0]    op,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rs1,
  output logic [RW-1:0] rs2,
  output logic          uses_rs1,
  output logic          uses_rs2,
  output logic          writes_rd,
  output logic [31:0]   imm_sext
);

  logic [3:0] raw_op;

  assign raw_op   = instr[OP_HI:OP_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign rs1      = instr[RS1_HI:RS1_LO];
  assign rs2      = instr[RS2_HI:RS2_LO];
  assign imm_sext = sext_imm(instr[IMM_HI:IMM_LO]);

  // Unknown opcodes decode as NOP so they can never write or create hazards
  always_comb begin
    op        = OP_NOP;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    if (IS_MEM == 1'b1) begin
      case (raw_op)
        MOP_LOAD:  begin op = raw_op; uses_rs1 = 1'b1; writes_rd = 1'b1; end
        MOP_STORE: begin op = raw_op; uses_rs1 = 1'b1; uses_rs2  = 1'b1; end
        default:   ;
      endcase
    end else begin
      case (raw_op)
        OP_ADD, OP_SUB, OP_AND: begin
          op = raw_op; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        end
        OP_ADDI:        begin op = raw_op; uses_rs1 = 1'b1; writes_rd = 1'b1; end
        OP_BRN, OP_JMP: begin op = raw_op; uses_rs1 = 1'b1; end
        default:        ;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage of the 2-slot VLIW pipe: RF read, load-use stall FSM, ID/EX register.
// Optional ID_SLOT_CONFLICT_EN traps bundles whose two slots write the same register.
module id_stage
  import id_defs::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         p1_aluInstr,
  input  logic [15:0]         p1_memInstr,
  input  logic [31:0]         p1_pc,
  input  logic                flush,
  input  logic [3:0][31:0]    rf_rdata,
  output logic [3:0][RW-1:0]  rf_raddr,
  output logic                pcWrite,
  output logic                p1_pipeline_regWrite,
  output logic [3:0]          p2_alu_op,
  output logic [RW-1:0]       p2_alu_rd,
  output logic [31:0]         p2_alu_a,
  output logic [31:0]         p2_alu_b,
  output logic                p2_isBranch,
  output logic                isJump,
  output logic [31:0]         pc_branchTarget,
  output logic [31:0]         pc_jumpTarget,
  output logic [1:0]          p2_mem_op,
  output logic [RW-1:0]       p2_mem_rd,
  output logic [31:0]         p2_mem_base,
  output logic [31:0]         p2_mem_wdata,
  output logic                isException,
  output logic [0:0]          dbg_state
);

  logic [3:0]    alu_op, mem_op;
  logic [RW-1:0] alu_rd, alu_rs1, alu_rs2, mem_rd, mem_rs1, mem_rs2;
  logic          alu_u1, alu_u2, alu_wr, mem_u1, mem_u2, mem_wr;
  logic [31:0]   alu_imm, unused_mem_imm;

  logic [0:0]    state;
  logic [31:0]   alu_a_d, alu_b_d, base_d, wdata_d, br_target_d;
  logic [1:0]    mem_op_d;
  logic          hazard, stall, conflict, bubble;

  id_slot_decode #(.IS_MEM(1'b0)) u_alu_dec (
    .instr(p1_aluInstr), .op(alu_op), .rd(alu_rd), .rs1(alu_rs1), .rs2(alu_rs2),
    .uses_rs1(alu_u1), .uses_rs2(alu_u2), .writes_rd(alu_wr), .imm_sext(alu_imm)
  );

  id_slot_decode #(.IS_MEM(1'b1)) u_mem_dec (
    .instr(p1_memInstr), .op(mem_op), .rd(mem_rd), .rs1(mem_rs1), .rs2(mem_rs2),
    .uses_rs1(mem_u1), .uses_rs2(mem_u2), .writes_rd(mem_wr), .imm_sext(unused_mem_imm)
  );

  assign rf_raddr[0] = alu_rs1;
  assign rf_raddr[1] = alu_rs2;
  assign rf_raddr[2] = mem_rs1;
  assign rf_raddr[3] = mem_rs2;

  // Operands a slot does not use are forced to zero so EX sees clean values
  always_comb begin
    alu_a_d     = alu_u1 ? reg_val(alu_rs1, rf_rdata[0]) : 32'd0;
    alu_b_d     = (alu_op == OP_ADDI) ? alu_imm
                : (alu_u2 ? reg_val(alu_rs2, rf_rdata[1]) : 32'd0);
    base_d      = mem_u1 ? reg_val(mem_rs1, rf_rdata[2]) : 32'd0;
    wdata_d     = mem_u2 ? reg_val(mem_rs2, rf_rdata[3]) : 32'd0;
    br_target_d = p1_pc + (alu_imm << 2);
    mem_op_d    = MEM_NOP;
    case (mem_op)
      MOP_LOAD:  mem_op_d = MEM_LOAD;
      MOP_STORE: mem_op_d = MEM_STORE;
      default:   mem_op_d = MEM_NOP;
    endcase
  end

  // A load in EX whose result is needed by any source of the bundle in ID
  assign hazard = (p2_mem_op == MEM_LOAD) && (p2_mem_rd != '0) &&
                  ((alu_u1 && (alu_rs1 == p2_mem_rd)) || (alu_u2 && (alu_rs2 == p2_mem_rd)) ||
                   (mem_u1 && (mem_rs1 == p2_mem_rd)) || (mem_u2 && (mem_rs2 == p2_mem_rd)));

  assign stall                = (state == ST_RUN) && hazard && !flush;
  assign pcWrite              = ~stall;
  assign p1_pipeline_regWrite = ~stall;
  assign dbg_state            = state;

`ifdef ID_SLOT_CONFLICT_EN
  assign conflict = alu_wr && mem_wr && (alu_rd == mem_rd) && (alu_rd != '0);

  // Raised only when the offending bundle would otherwise have issued
  always_ff @(posedge clk) begin
    if (!reset) isException <= 1'b0;
    else        isException <= conflict && !flush && !stall;
  end
`else
  assign conflict    = 1'b0;
  assign isException = 1'b0;
`endif

  assign bubble = flush || stall || conflict;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= stall ? ST_STALL : ST_RUN;

    if (!reset || bubble) begin
      p2_alu_op       <= OP_NOP;
      p2_alu_rd       <= '0;
      p2_alu_a        <= '0;
      p2_alu_b        <= '0;
      p2_isBranch     <= 1'b0;
      isJump          <= 1'b0;
      pc_branchTarget <= '0;
      pc_jumpTarget   <= '0;
      p2_mem_op       <= MEM_NOP;
      p2_mem_rd       <= '0;
      p2_mem_base     <= '0;
      p2_mem_wdata    <= '0;
    end else begin
      p2_alu_op       <= alu_op;
      p2_alu_rd       <= alu_wr ? alu_rd : '0;
      p2_alu_a        <= alu_a_d;
      p2_alu_b        <= alu_b_d;
      p2_isBranch     <= (alu_op == OP_BRN);
      isJump          <= (alu_op == OP_JMP);
      pc_branchTarget <= (alu_op == OP_BRN) ? br_target_d : 32'd0;
      pc_jumpTarget   <= (alu_op == OP_JMP) ? alu_a_d : 32'd0;
      p2_mem_op       <= mem_op_d;
      p2_mem_rd       <= mem_wr ? mem_rd : '0;
      p2_mem_base     <= base_d;
      p2_mem_wdata    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scoreboard of expected ID/EX bundles.
// Expectations follow ID_SLOT_CONFLICT_EN when it is defined for the build.
module tb_id_stage;
  import id_defs::*;

  localparam int EW = 207;

  logic             clk, reset, flush;
  logic [15:0]      p1_aluInstr, p1_memInstr;
  logic [31:0]      p1_pc;
  logic [3:0][31:0] rf_rdata;
  logic [3:0][2:0]  rf_raddr;
  logic             pcWrite, p1_pipeline_regWrite;
  logic [3:0]       p2_alu_op;
  logic [2:0]       p2_alu_rd, p2_mem_rd;
  logic [31:0]      p2_alu_a, p2_alu_b, pc_branchTarget, pc_jumpTarget;
  logic [31:0]      p2_mem_base, p2_mem_wdata;
  logic             p2_isBranch, isJump, isException;
  logic [1:0]       p2_mem_op;
  logic [0:0]       dbg_state;

  logic [31:0]      rf_model [8];
  logic [EW-1:0]    exp_q[$];
  int               n_tests, n_fail;

  id_stage dut (
    .clk(clk), .reset(reset), .p1_aluInstr(p1_aluInstr), .p1_memInstr(p1_memInstr),
    .p1_pc(p1_pc), .flush(flush), .rf_rdata(rf_rdata), .rf_raddr(rf_raddr),
    .pcWrite(pcWrite), .p1_pipeline_regWrite(p1_pipeline_regWrite),
    .p2_alu_op(p2_alu_op), .p2_alu_rd(p2_alu_rd), .p2_alu_a(p2_alu_a), .p2_alu_b(p2_alu_b),
    .p2_isBranch(p2_isBranch), .isJump(isJump), .pc_branchTarget(pc_branchTarget),
    .pc_jumpTarget(pc_jumpTarget), .p2_mem_op(p2_mem_op), .p2_mem_rd(p2_mem_rd),
    .p2_mem_base(p2_mem_base), .p2_mem_wdata(p2_mem_wdata), .isException(isException),
    .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model answering the DUT's read ports
  always_comb begin
    for (int i = 0; i < 4; i++) rf_rdata[i] = rf_model[rf_raddr[i]];
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] rfv(input logic [2:0] r);
    return (r == 3'd0) ? 32'd0 : rf_model[r];
  endfunction

  function automatic logic [EW-1:0] mk_exp(
    input logic [3:0] aop, input logic [2:0] ard, input logic [31:0] a, b,
    input logic br, jmp, input logic [31:0] bt, jt, input logic [1:0] mop,
    input logic [2:0] mrd, input logic [31:0] base, wdata, input logic exc);
    return {aop, ard, a, b, br, jmp, bt, jt, mop, mrd, base, wdata, exc};
  endfunction

  function automatic logic [EW-1:0] act();
    return {p2_alu_op, p2_alu_rd, p2_alu_a, p2_alu_b, p2_isBranch, isJump, pc_branchTarget,
            pc_jumpTarget, p2_mem_op, p2_mem_rd, p2_mem_base, p2_mem_wdata, isException};
  endfunction

  // Reference decode of an issuing bundle (no stall/flush/conflict)
  function automatic logic [EW-1:0] model(input logic [15:0] ai, mi, input logic [31:0] pc);
    logic [3:0] aop; logic [2:0] ard, mrd; logic [1:0] mop;
    logic [31:0] a, b, bt, jt, base, wdata, imm; logic br, jmp;
    aop = OP_NOP; ard = 0; a = 0; b = 0; br = 0; jmp = 0; bt = 0; jt = 0;
    mop = MEM_NOP; mrd = 0; base = 0; wdata = 0;
    imm = {{29{ai[2]}}, ai[2:0]};
    case (ai[15:12])
      OP_ADD, OP_SUB, OP_AND: begin aop = ai[15:12]; ard = ai[11:9]; a = rfv(ai[8:6]); b = rfv(ai[5:3]); end
      OP_ADDI: begin aop = OP_ADDI; ard = ai[11:9]; a = rfv(ai[8:6]); b = imm; end
      OP_BRN:  begin aop = OP_BRN; a = rfv(ai[8:6]); br = 1; bt = pc + (imm << 2); end
      OP_JMP:  begin aop = OP_JMP; a = rfv(ai[8:6]); jmp = 1; jt = a; end
      default: ;
    endcase
    case (mi[15:12])
      MOP_LOAD:  begin mop = MEM_LOAD; mrd = mi[11:9]; base = rfv(mi[8:6]); end
      MOP_STORE: begin mop = MEM_STORE; base = rfv(mi[8:6]); wdata = rfv(mi[5:3]); end
      default: ;
    endcase
    return mk_exp(aop, ard, a, b, br, jmp, bt, jt, mop, mrd, base, wdata, 1'b0);
  endfunction

  // Driver
  task automatic drive(input logic [15:0] ai, mi, input logic [31:0] pc, input logic fl);
    p1_aluInstr = ai; p1_memInstr = mi; p1_pc = pc; flush = fl;
  endtask

  task automatic test_reset();
    drive(enc(OP_ADD, 1, 2, 3, 0), enc(MOP_STORE, 0, 2, 3, 0), 32'h40, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (act() !== '0) begin n_fail++; $display("FAIL reset_p2: got %h exp 0", act()); end
    n_tests++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL reset_pcWrite: got %b exp 1", pcWrite); end
    n_tests++; if (p1_pipeline_regWrite !== 1'b1) begin n_fail++; $display("FAIL reset_regWrite: got %b exp 1", p1_pipeline_regWrite); end
    n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL reset_state: got %b exp %b", dbg_state, ST_RUN); end
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [EW-1:0] e_v;
    drive(enc(OP_ADD, 1, 2, 3, 0), 16'h0, 32'h80, 1'b0);
    #1;
    n_tests++; if (rf_raddr[0] !== 3'd2 || rf_raddr[1] !== 3'd3) begin
      n_fail++; $display("FAIL add_raddr: got %0d,%0d exp 2,3", rf_raddr[0], rf_raddr[1]); end
    exp_q.push_back(mk_exp(OP_ADD, 3'd1, 32'd5, 32'd7, 0, 0, 0, 0, MEM_NOP, 0, 0, 0, 0));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL add_issue: got %h exp %h", act(), e_v); end
  endtask

  task automatic test_alu_ops();
    logic [EW-1:0] e_v;
    logic [15:0] ai_t [5];
    logic [15:0] mi_t [5];
    ai_t[0] = enc(OP_SUB, 3, 1, 2, 0);   mi_t[0] = 16'h0;
    ai_t[1] = enc(OP_AND, 4, 2, 3, 0);   mi_t[1] = enc(MOP_STORE, 0, 2, 3, 0);
    ai_t[2] = enc(OP_ADDI, 6, 1, 0, 5);  mi_t[2] = 16'h0;
    ai_t[3] = enc(OP_ADD, 7, 0, 1, 0);   mi_t[3] = enc(MOP_STORE, 0, 0, 0, 0);
    ai_t[4] = enc(4'hF, 2, 1, 1, 1);     mi_t[4] = enc(4'h7, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(ai_t[i], mi_t[i], 32'h1000 + 32'(i * 4), 1'b0);
      exp_q.push_back(model(ai_t[i], mi_t[i], p1_pc));
      @(posedge clk); #1;
      e_v = exp_q.pop_front();
      n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL alu_ops[%0d]: got %h exp %h", i, act(), e_v); end
    end
  endtask

  task automatic test_load_use();
    logic [EW-1:0] e_v;
    drive(16'h0, enc(MOP_LOAD, 4, 2, 0, 0), 32'h200, 1'b0);
    exp_q.push_back(mk_exp(OP_NOP, 0, 0, 0, 0, 0, 0, 0, MEM_LOAD, 3'd4, 32'd5, 0, 0));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL lu_load: got %h exp %h", act(), e_v); end
    drive(enc(OP_ADD, 5, 4, 1, 0), 16'h0, 32'h204, 1'b0);
    #1;
    n_tests++; if (pcWrite !== 1'b0 || p1_pipeline_regWrite !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall_ctrl: got %b%b exp 00", pcWrite, p1_pipeline_regWrite); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL lu_bubble: got %h exp %h", act(), e_v); end
    n_tests++; if (pcWrite !== 1'b1 || dbg_state !== ST_STALL) begin
      n_fail++; $display("FAIL lu_release: got pcWrite=%b state=%b exp 1,%b", pcWrite, dbg_state, ST_STALL); end
    rf_model[4] = 32'hCAFE_0004;
    exp_q.push_back(mk_exp(OP_ADD, 3'd5, 32'hCAFE_0004, 32'h11, 0, 0, 0, 0, MEM_NOP, 0, 0, 0, 0));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL lu_reissue: got %h exp %h", act(), e_v); end
    n_tests++; if (pcWrite !== 1'b1 || dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL lu_run: got pcWrite=%b state=%b exp 1,%b", pcWrite, dbg_state, ST_RUN); end
  endtask

  task automatic test_flush_hazard();
    logic [EW-1:0] e_v;
    drive(16'h0, enc(MOP_LOAD, 4, 2, 0, 0), 32'h300, 1'b0);
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL fh_load: got %h exp %h", act(), e_v); end
    drive(enc(OP_ADD, 5, 4, 1, 0), 16'h0, 32'h304, 1'b1);
    #1;
    n_tests++; if (pcWrite !== 1'b1 || p1_pipeline_regWrite !== 1'b1) begin
      n_fail++; $display("FAIL fh_ctrl: got %b%b exp 11", pcWrite, p1_pipeline_regWrite); end
    exp_q.push_back('0);
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL fh_bubble: got %h exp %h", act(), e_v); end
    n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL fh_state: got %b exp %b", dbg_state, ST_RUN); end
    flush = 1'b0;
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL fh_next: got %h exp %h", act(), e_v); end
  endtask

  task automatic test_branch_jump();
    logic [EW-1:0] e_v;
    logic [15:0]   ai_t [3];
    logic [31:0]   pc_t [3];
    logic [EW-1:0] ex_t [3];
    ai_t[0] = enc(OP_BRN, 0, 1, 0, 3'b111); pc_t[0] = 32'h100;
    ex_t[0] = mk_exp(OP_BRN, 0, 32'h11, 0, 1, 0, 32'hFC, 0, MEM_NOP, 0, 0, 0, 0);
    ai_t[1] = enc(OP_BRN, 0, 2, 0, 3'b001); pc_t[1] = 32'hFFFF_FFFC;
    ex_t[1] = mk_exp(OP_BRN, 0, 32'd5, 0, 1, 0, 32'h0, 0, MEM_NOP, 0, 0, 0, 0);
    ai_t[2] = enc(OP_JMP, 0, 6, 0, 0);      pc_t[2] = 32'h500;
    ex_t[2] = mk_exp(OP_JMP, 0, 32'h1000, 0, 0, 1, 0, 32'h1000, MEM_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(ai_t[i], 16'h0, pc_t[i], 1'b0);
      exp_q.push_back(ex_t[i]);
      @(posedge clk); #1;
      e_v = exp_q.pop_front();
      n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL br_jmp[%0d]: got %h exp %h", i, act(), e_v); end
    end
  endtask

  task automatic test_conflict();
    logic [EW-1:0] e_v;
    drive(enc(OP_ADD, 2, 1, 1, 0), enc(MOP_LOAD, 2, 3, 0, 0), 32'h600, 1'b0);
`ifdef ID_SLOT_CONFLICT_EN
    exp_q.push_back(EW'(1));
`else
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
`endif
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL conflict: got %h exp %h", act(), e_v); end
    drive(16'h0, 16'h0, 32'h604, 1'b0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL conflict_clear: got %h exp %h", act(), e_v); end
    drive(enc(OP_ADD, 0, 1, 1, 0), enc(MOP_LOAD, 0, 3, 0, 0), 32'h608, 1'b0);
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL conflict_r0: got %h exp %h", act(), e_v); end
    drive(enc(OP_ADD, 1, 0, 0, 0), 16'h0, 32'h60C, 1'b0);
    #1;
    n_tests++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL r0_no_hazard: got %b exp 1", pcWrite); end
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL r0_issue: got %h exp %h", act(), e_v); end
  endtask

  task automatic test_reset_mid_stall();
    logic [EW-1:0] e_v;
    drive(16'h0, enc(MOP_LOAD, 4, 2, 0, 0), 32'h700, 1'b0);
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL rms_load: got %h exp %h", act(), e_v); end
    drive(enc(OP_SUB, 5, 1, 4, 0), 16'h0, 32'h704, 1'b0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v || dbg_state !== ST_STALL) begin
      n_fail++; $display("FAIL rms_stall: got %h state=%b exp %h state=%b", act(), dbg_state, e_v, ST_STALL); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (act() !== '0 || dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL rms_reset: got %h state=%b exp 0 state=%b", act(), dbg_state, ST_RUN); end
    reset = 1'b1;
    exp_q.push_back(model(p1_aluInstr, p1_memInstr, p1_pc));
    @(posedge clk); #1;
    e_v = exp_q.pop_front();
    n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL rms_after: got %h exp %h", act(), e_v); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] e_v;
    logic [15:0]   ai, mi;
    logic [3:0]    mop;
    logic          fl;
    for (int i = 0; i < 40; i++) begin
      for (int r = 1; r < 8; r++) rf_model[r] = $urandom;
      case ($urandom_range(0, 2))
        0:       mop = 4'h0;
        1:       mop = MOP_STORE;
        default: mop = 4'hF;
      endcase
      ai = enc(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      mi = enc(mop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'd0);
      fl = ($urandom_range(0, 7) == 0);
      drive(ai, mi, $urandom, fl);
      exp_q.push_back(fl ? EW'(0) : model(ai, mi, p1_pc));
      @(posedge clk); #1;
      e_v = exp_q.pop_front();
      n_tests++; if (act() !== e_v) begin n_fail++; $display("FAIL b2b[%0d]: got %h exp %h", i, act(), e_v); end
    end
    flush = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    flush   = 1'b0;
    p1_aluInstr = '0; p1_memInstr = '0; p1_pc = '0;
    rf_model[0] = 32'hDEAD_BEEF; rf_model[1] = 32'h11;   rf_model[2] = 32'd5;
    rf_model[3] = 32'd7;         rf_model[4] = 32'h40;   rf_model[5] = 32'h55;
    rf_model[6] = 32'h1000;      rf_model[7] = 32'h77;
    test_reset();
    test_add();
    test_alu_ops();
    test_load_use();
    test_flush_hazard();
    test_branch_jump();
    test_conflict();
    test_reset_mid_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
